// File: rtl/spi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : spi_pkg                                                |
// | Brief   : Shared types and constants for the SPI receiver slice. |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package spi_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // SPI modes encoded as {CKP, CPH}
  localparam logic [1:0] MODE00 = 2'b00;
  localparam logic [1:0] MODE01 = 2'b01;
  localparam logic [1:0] MODE10 = 2'b10;
  localparam logic [1:0] MODE11 = 2'b11;

  localparam int DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : spi_sync_edge                                           |
// | Brief  : Multi-flop synchronizer with registered edge detection. |
// |          sync, rise and fall are all registered and mutually     |
// |          aligned: sync is the level that the strobes refer to.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   settled;

  assign settled = stages[SYNC_STAGES-1];

  // Synchronizer chain, then one flop holding the previous settled level
  // alongside registered edge strobes so level and strobes line up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
      sync   <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      sync   <= settled;
      rise   <= settled & ~sync;
      fall   <= ~settled & sync;
    end
  end

endmodule
`default_nettype wire

// File: rtl/receiver_spi.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : receiver_spi                                            |
// | Brief  : Oversampling SPI slave, LSB-first, full duplex, all     |
// |          four CKP/CPH modes, back-to-back words under one CS.    |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module receiver_spi
  import spi_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CKP,
  input  logic             CPH,
  input  logic             SCK,
  input  logic             CS,
  input  logic             MOSI,
  input  logic [WIDTH-1:0] tx_data,
  output logic             MISO,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int             CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  C_FULL = CW'(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    count, count_after;
  logic [WIDTH-1:0] rx_shift, tx_shift, tx_shifted;
  logic             sck_norm, lead, trail, cs_rise, cs_fall, mosi_s;
  logic             sck_level_unused, cs_level_unused;
  logic             mosi_rise_unused, mosi_fall_unused;
  logic             sample_en, shift_en, start, frame_abort;

  // SCK is normalised so its idle level is always 0: rise = leading edge,
  // fall = trailing edge, and the synchronizer resets to the idle level.
  assign sck_norm   = SCK ^ CKP;
  assign tx_shifted = tx_shift >> 1;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst(rst), .din(sck_norm),
    .sync(sck_level_unused), .rise(lead), .fall(trail)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(CS),
    .sync(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .rst(rst), .din(MOSI),
    .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state plus per-cycle strobes for the datapath
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    start       = 1'b0;
    sample_en   = 1'b0;
    shift_en    = 1'b0;
    frame_abort = 1'b0;
    count_after = count;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy        = 1'b1;
        sample_en   = CPH ? trail : lead;
        // CPH=0: the trailing edge right after a completed word must not
        // shift, or the freshly reloaded bit 0 would be lost.
        shift_en    = !cs_rise && (CPH ? lead : (trail && count != '0));
        count_after = count + CW'(sample_en);
        if (cs_rise) begin
          state_next  = IDLE;
          frame_abort = (count_after != '0) && (count_after != C_FULL);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift registers, bit counter, word completion and MISO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MISO      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      count     <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (start) begin
        tx_shift <= tx_data;
        rx_shift <= '0;
        count    <= '0;
        MISO     <= CPH ? 1'b0 : tx_data[0];
      end else if (count == C_FULL) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        count    <= '0;
        tx_shift <= tx_data;
        if (state == SHIFT && cs_rise)   MISO <= 1'b0;
        else if (state == SHIFT && !CPH) MISO <= tx_data[0];
      end else begin
        if (sample_en) begin
          rx_shift <= {mosi_s, rx_shift[WIDTH-1:1]};
          count    <= count_after;
        end
        if (shift_en) begin
          tx_shift <= tx_shifted;
          MISO     <= CPH ? tx_shift[0] : tx_shifted[0];
        end
        if (frame_abort) begin
          frame_err <= 1'b1;
          count     <= '0;
        end
        if (state == SHIFT && cs_rise) MISO <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/receiver_spi.md
Name: receiver_spi

Overview:
- SPI slave (receiver) end of the team's SPI link. Runs on the local system clock and oversamples the incoming SCK, CS and MOSI lines.
- Captures MOSI bits LSB-first into a WIDTH-bit word and presents it with a one-cycle valid strobe.
- Full duplex: shifts a preloaded response word out on MISO LSB-first during the same frame.
- Supports all four CKP/CPH modes and back-to-back words under one CS assertion.

Parameters:
- WIDTH, 8, bits per word.
- SYNC_STAGES, 2, synchronizer depth on SCK/CS/MOSI (minimum 2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- CKP  input  1  SCK idle level (0 = idle low, 1 = idle high); static while CS is high
- CPH  input  1  0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge
- SCK  input  1  serial clock from master, asynchronous
- CS  input  1  chip select, active low, asynchronous
- MOSI  input  1  serial data from master
- tx_data  input  WIDTH  response word; latched at frame start and at each word boundary
- MISO  output  1  serial data to master
- rx_data  output  WIDTH  last completed received word
- rx_valid  output  1  one-clk pulse when rx_data updates
- busy  output  1  high while in SHIFT
- frame_err  output  1  one-clk pulse when CS deasserts mid-word

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, MISO=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, bit counter=0, shift registers=0, synchronizers loaded to their idle values (SCK=CKP, CS=1).
- Input path:
  - SCK, CS and MOSI each pass through SYNC_STAGES flops, followed by a one-flop edge detector.
  - Leading edge = transition away from CKP; trailing edge = transition back to CKP.
  - Requirement on the master: SCK high and low phases are each ≥ 2 clk periods.
- State IDLE:
  - MISO=0.
  - On synchronized CS falling: load tx_shift=tx_data, clear bit counter and rx_shift, go to SHIFT.
  - If CPH=0, MISO=tx_data[0] from the next clk edge onward.
- State SHIFT (busy=1):
  - Sampling edge: rx_shift={MOSI_sync, rx_shift[WIDTH-1:1]}; count++.
  - Shift edge (CPH=0): tx_shift>>=1, MISO=new tx_shift[0].
  - Shift edge (CPH=1): MISO=tx_shift[0], then tx_shift>>=1.
  - CPH=1: the first leading edge drives bit 0.
- Word completion:
  - On the sampling edge where count reaches WIDTH, next clk: rx_data=completed word, rx_valid=1 for exactly one cycle, count=0, tx_shift reloaded from tx_data.
  - If CPH=0, MISO immediately shows the new bit 0 (continuous framing). Stay in SHIFT.
- Latency: rx_valid rises SYNC_STAGES+2 clk edges after the clk edge that first registers the raw final sampling edge (4 with defaults).
- CS rising (synchronized):
  - count==0: go to IDLE quietly.
  - 0<count<WIDTH: frame_err pulse one cycle; rx_data and rx_valid unaffected; partial word discarded; go to IDLE.
- Simultaneous final sampling edge and CS rise in the same synchronized cycle: word completes (rx_valid=1), no frame_err.
- SCK edges while CS is high are ignored.
- CKP/CPH changes during SHIFT are undefined behaviour; they are sampled combinationally.
- Reset mid-frame: immediate return to the reset state; the next frame requires a fresh CS falling edge.
- Counter width is $clog2(WIDTH+1); no wrap is possible beyond WIDTH.

Decomposition:
- Package spi_pkg:
  - state encoding localparams (IDLE=1'b0, SHIFT=1'b1);
  - mode constants MODE00..MODE11 as {CKP,CPH};
  - DEFAULT_WIDTH=8.
- Sub-module spi_sync_edge, parameterised by SYNC_STAGES and reset value:
  - N-flop synchronizer plus registered previous value;
  - outputs sync, rise, fall.
  - Instantiated three times: SCK, CS, MOSI (MOSI uses sync only).

Test Plan:
- Mode 00, tx_data=8'h3C, master sends 8'hA5 LSB-first, SCK=clk/4 → rx_data=8'hA5, one rx_valid pulse; MISO bits observed on sampling edges = 0,0,1,1,1,1,0,0.
- Modes 01/10/11, master sends 8'h5A, tx_data=8'hC3 → rx_data=8'h5A and master-captured word=8'hC3 in each mode.
- One CS assertion with 16 SCK cycles, MOSI=8'h12 then 8'h34, tx_data changed 8'hAA→8'h55 before word 2 → two rx_valid pulses, with rx_data 8'h12 then 8'h34; MISO returns 8'hAA then 8'h55.
- CS released after 3 sampling edges → frame_err=1 for one cycle, no rx_valid, rx_data keeps its previous value, busy=0; next full frame 8'hFF is received correctly.
- rst pulled low after 5 bits → all outputs 0 asynchronously; after release, frame 8'h81 → rx_data=8'h81.
- SCK toggling 8 times with CS high → no rx_valid, busy=0, MISO=0.
